// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the PC sequencer
// Purpose: default address width, fetch increment, branch offset shift and
//          the encoding of the next-PC source.
// Ports:   none (package)
package cpu_pkg;

  localparam int ADDR_WIDTH_DEF  = 64;
  localparam int INSTR_BYTES_DEF = 4;
  localparam int IMM_SHIFT_DEF   = 2;

  typedef enum logic [1:0] {
    PC_SEQ     = 2'd0,
    PC_BRANCH  = 2'd1,
    PC_RET_RAS = 2'd2,
    PC_RET_REG = 2'd3
  } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with saturating count
// Purpose: LIFO of return addresses. The oldest entry is silently overwritten
//          when a push lands on a full stack, and the sticky overflow flag is
//          set. A simultaneous push+pop on a non-empty stack replaces the top.
// Ports:
//   clk        in   clock, rising edge
//   resetl     in   synchronous active-low reset
//   en         in   1 = apply push/pop this edge (0 = hold everything)
//   push       in   push push_data
//   pop        in   pop (ignored when empty)
//   push_data  in   WIDTH  value to push
//   top_data   out  WIDTH  current top entry (meaningful when count>0)
//   count      out  valid entries, 0..DEPTH
//   overflow   out  sticky: a push was performed while full
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       resetl,
  input  logic                       en,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    top;
  logic             nonempty;
  logic             full;
  logic             do_replace;
  logic             do_push;
  logic             do_pop;
  logic             wr_en;
  logic [PW-1:0]    wr_addr;

  assign nonempty = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign top_data = mem[top];

  // Push and pop together on a non-empty stack is a replace of the top; on an
  // empty stack the pop has nothing to remove, so it degenerates to a push.
  always_comb begin
    do_replace = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    if (en) begin
      if (push && pop && nonempty) begin
        do_replace = 1'b1;
      end else if (push) begin
        do_push = 1'b1;
      end else if (pop && nonempty) begin
        do_pop = 1'b1;
      end
    end
  end

  assign wr_en   = do_replace | do_push;
  assign wr_addr = do_push ? top + PW'(1) : top;

  // Storage carries no reset; count gates every read of stale entries.
  always_ff @(posedge clk) begin
    if (resetl && wr_en) begin
      mem[wr_addr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetl) begin
      top      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (do_push) begin
      top <= top + PW'(1);
      if (full) begin
        overflow <= 1'b1;
      end else begin
        count <= count + CW'(1);
      end
    end else if (do_pop) begin
      top   <= top - PW'(1);
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered program counter with branch and RAS select
// Purpose: holds the architectural PC, selects the next PC among sequential,
//          PC-relative branch and return targets, and maintains the RAS.
// Ports:
//   CLK           in   clock, rising edge
//   resetl        in   synchronous active-low reset
//   stall         in   1 = hold PC and RAS this cycle
//   SignExtImm    in   ADDR_WIDTH  branch offset in instructions
//   RegTarget     in   ADDR_WIDTH  register target used by RET when RAS empty
//   Branch        in   conditional branch
//   BranchInvert  in   0 = CBZ sense, 1 = CBNZ sense
//   ALUZero       in   ALU zero flag
//   Uncondbranch  in   B / BL
//   Link          in   with Uncondbranch (or Ret): push return address
//   Ret           in   RET instruction
//   CurrentPC     out  ADDR_WIDTH  registered PC
//   NextPC        out  ADDR_WIDTH  combinational next PC
//   ras_miss      out  registered pulse: RET with empty RAS
//   ras_overflow  out  sticky: push performed while RAS full
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                        ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0]     RESET_PC    = '0,
  parameter int                        IMM_SHIFT   = IMM_SHIFT_DEF,
  parameter int                        INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int                        RAS_DEPTH   = 4
) (
  input  logic                  CLK,
  input  logic                  resetl,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] SignExtImm,
  input  logic [ADDR_WIDTH-1:0] RegTarget,
  input  logic                  Branch,
  input  logic                  BranchInvert,
  input  logic                  ALUZero,
  input  logic                  Uncondbranch,
  input  logic                  Link,
  input  logic                  Ret,
  output logic [ADDR_WIDTH-1:0] CurrentPC,
  output logic [ADDR_WIDTH-1:0] NextPC,
  output logic                  ras_miss,
  output logic                  ras_overflow
);

  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic                  taken_cond;
  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] branch_pc;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic [CW-1:0]         ras_count;
  logic                  ras_nonempty;
  logic                  ras_push;
  pc_src_e               pc_src;

  assign taken_cond   = Branch & (ALUZero ^ BranchInvert);
  assign seq_pc       = CurrentPC + ADDR_WIDTH'(INSTR_BYTES);
  assign branch_pc    = CurrentPC + (SignExtImm << IMM_SHIFT);
  assign ras_nonempty = (ras_count != '0);

  // Link only matters alongside a branch-with-link or a return; with Ret it
  // becomes a replace of the top entry inside the stack.
  assign ras_push = Link & (Uncondbranch | Ret);

  always_comb begin
    pc_src = PC_SEQ;
    if (Ret) begin
      pc_src = ras_nonempty ? PC_RET_RAS : PC_RET_REG;
    end else if (Uncondbranch || taken_cond) begin
      pc_src = PC_BRANCH;
    end
  end

  always_comb begin
    NextPC = seq_pc;
    case (pc_src)
      PC_BRANCH:  NextPC = branch_pc;
      PC_RET_RAS: NextPC = ras_top;
      PC_RET_REG: NextPC = RegTarget;
      default:    NextPC = seq_pc;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      CurrentPC <= RESET_PC;
      ras_miss  <= 1'b0;
    end else if (stall) begin
      ras_miss <= 1'b0;
    end else begin
      CurrentPC <= NextPC;
      ras_miss  <= Ret & ~ras_nonempty;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_ras (
    .clk       (CLK),
    .resetl    (resetl),
    .en        (~stall),
    .push      (ras_push),
    .pop       (Ret),
    .push_data (seq_pc),
    .top_data  (ras_top),
    .count     (ras_count),
    .overflow  (ras_overflow)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        CLK = 1'b0;
  logic        resetl, stall, Branch, BranchInvert, ALUZero, Uncondbranch, Link, Ret;
  logic [63:0] SignExtImm, RegTarget, CurrentPC, NextPC;
  logic        ras_miss, ras_overflow;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_pc;
  logic [63:0] m_ras[$];
  logic        m_miss, m_ovf;
  logic [63:0] got_next;

  always #5 CLK = ~CLK;

  pc_sequencer #(
    .ADDR_WIDTH  (64),
    .RESET_PC    (RST_PC),
    .IMM_SHIFT   (2),
    .INSTR_BYTES (4),
    .RAS_DEPTH   (4)
  ) dut (
    .CLK          (CLK),
    .resetl       (resetl),
    .stall        (stall),
    .SignExtImm   (SignExtImm),
    .RegTarget    (RegTarget),
    .Branch       (Branch),
    .BranchInvert (BranchInvert),
    .ALUZero      (ALUZero),
    .Uncondbranch (Uncondbranch),
    .Link         (Link),
    .Ret          (Ret),
    .CurrentPC    (CurrentPC),
    .NextPC       (NextPC),
    .ras_miss     (ras_miss),
    .ras_overflow (ras_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_next();
    logic [63:0] n;
    if (Ret) n = (m_ras.size() > 0) ? m_ras[$] : RegTarget;
    else if (Uncondbranch || (Branch && (ALUZero != BranchInvert))) n = m_pc + (SignExtImm * 64'd4);
    else n = m_pc + 64'd4;
    return n;
  endfunction

  // One clock: drive at the falling edge, check NextPC, then check state after
  // the rising edge against the queue-based model.
  task automatic step(input logic rst, input logic st, input logic br, input logic inv,
                      input logic z, input logic ub, input logic lk, input logic rt,
                      input logic [63:0] imm, input logic [63:0] rtgt);
    logic [63:0] exp_next;
    @(negedge CLK);
    resetl = ~rst; stall = st; Branch = br; BranchInvert = inv; ALUZero = z;
    Uncondbranch = ub; Link = lk; Ret = rt; SignExtImm = imm; RegTarget = rtgt;
    #1;
    exp_next = model_next();
    got_next = NextPC;
    check("nextpc", NextPC, exp_next);
    if (rst) begin
      m_pc = RST_PC; m_ras.delete(); m_miss = 0; m_ovf = 0;
    end else if (st) begin
      m_miss = 0;
    end else begin
      m_miss = rt && (m_ras.size() == 0);
      if (rt && m_ras.size() > 0) begin
        if (lk) m_ras[m_ras.size()-1] = m_pc + 64'd4;
        else    void'(m_ras.pop_back());
      end else if (lk && (ub || rt)) begin
        m_ras.push_back(m_pc + 64'd4);
        if (m_ras.size() > 4) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
      end
      m_pc = exp_next;
    end
    @(posedge CLK);
    #1;
    check("curpc", CurrentPC, m_pc);
    check("ras_miss", {63'd0, ras_miss}, {63'd0, m_miss});
    check("ras_ovf", {63'd0, ras_overflow}, {63'd0, m_ovf});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
  endtask

  task automatic goto(input logic [63:0] target);
    logic signed [63:0] d;
    d = signed'(target - m_pc);
    step(0, 0, 0, 0, 0, 1, 0, 0, 64'(d >>> 2), 64'd0);
  endtask

  task automatic bl(input logic st, input logic [63:0] imm);
    step(0, st, 0, 0, 0, 1, 1, 0, imm, 64'd0);
  endtask

  task automatic ret(input logic [63:0] rtgt);
    step(0, 0, 0, 0, 0, 0, 0, 1, 64'd0, rtgt);
  endtask

  initial begin
    resetl = 0; stall = 1; Branch = 0; BranchInvert = 0; ALUZero = 0;
    Uncondbranch = 0; Link = 0; Ret = 0; SignExtImm = '0; RegTarget = '0;
    m_pc = RST_PC; m_miss = 0; m_ovf = 0;

    // reset held two edges with stall asserted
    step(1, 1, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
    check("rst_pc", CurrentPC, 64'h1000);
    check("rst_ovf", {63'd0, ras_overflow}, 64'd0);
    idle();
    check("rel_pc1", CurrentPC, 64'h1004);
    idle();
    check("rel_pc2", CurrentPC, 64'h1008);

    // CBZ / CBNZ at 0x100, probed with stall so the PC stays put
    goto(64'h100);
    step(0, 1, 1, 0, 1, 0, 0, 0, -64'sd2, 64'd0);
    check("cbz_taken", got_next, 64'hF8);
    step(0, 1, 1, 1, 1, 0, 0, 0, -64'sd2, 64'd0);
    check("cbnz_nt", got_next, 64'h104);
    step(0, 1, 1, 1, 0, 0, 0, 0, -64'sd2, 64'd0);
    check("cbnz_taken", got_next, 64'hF8);

    // BL / RET / RET-miss
    goto(64'h200);
    bl(0, 64'h40);
    check("bl_pc", CurrentPC, 64'h300);
    ret(64'h0);
    check("ret_next", got_next, 64'h204);
    check("ret_pc", CurrentPC, 64'h204);
    check("ret_nomiss", {63'd0, ras_miss}, 64'd0);
    ret(64'h555C);
    check("ret_reg_pc", CurrentPC, 64'h555C);
    check("ret_miss", {63'd0, ras_miss}, 64'd1);
    idle();
    check("miss_pulse", {63'd0, ras_miss}, 64'd0);

    // overflow: five BLs into a four-deep stack
    for (int i = 1; i <= 5; i++) begin
      goto(64'(i * 16));
      bl(0, 64'h100);
    end
    check("ovf_set", {63'd0, ras_overflow}, 64'd1);
    ret(64'h8000); check("ovf_ret1", CurrentPC, 64'h54);
    ret(64'h8000); check("ovf_ret2", CurrentPC, 64'h44);
    ret(64'h8000); check("ovf_ret3", CurrentPC, 64'h34);
    ret(64'h8000); check("ovf_ret4", CurrentPC, 64'h24);
    ret(64'h8000); check("ovf_ret5", CurrentPC, 64'h8000);
    check("ovf_miss", {63'd0, ras_miss}, 64'd1);

    // stall during a BL, then a single push on release
    do_reset();
    check("midrst_ovf", {63'd0, ras_overflow}, 64'd0);
    goto(64'h400);
    for (int i = 0; i < 3; i++) begin
      bl(1, 64'h8);
      check("stall_next", got_next, 64'h420);
      check("stall_pc", CurrentPC, 64'h400);
    end
    bl(0, 64'h8);
    check("stall_rel", CurrentPC, 64'h420);
    ret(64'h9000); check("stall_ret1", CurrentPC, 64'h404);
    ret(64'h9000); check("stall_ret2", CurrentPC, 64'h9000);
    check("stall_miss", {63'd0, ras_miss}, 64'd1);

    // wrap-around both directions
    goto(64'hFFFF_FFFF_FFFF_FFFC);
    idle();
    check("wrap_up", CurrentPC, 64'h0);
    step(0, 0, 1, 0, 1, 0, 0, 0, -64'sd1, 64'd0);
    check("wrap_down", CurrentPC, 64'hFFFF_FFFF_FFFF_FFFC);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_st, r_br, r_inv, r_z, r_ub, r_lk, r_rt;
      logic [63:0] r_imm, r_tgt;
      r_rst = ($urandom_range(0, 99) == 0);
      r_st  = ($urandom_range(0, 4) == 0);
      r_br  = $urandom_range(0, 1);
      r_inv = $urandom_range(0, 1);
      r_z   = $urandom_range(0, 1);
      r_ub  = ($urandom_range(0, 3) == 0);
      r_lk  = $urandom_range(0, 1);
      r_rt  = ($urandom_range(0, 3) == 0);
      r_imm = 64'(signed'($urandom_range(0, 255)) - 128);
      r_tgt = {$urandom(), $urandom()} & ~64'd3;
      step(r_rst, r_st, r_br, r_inv, r_z, r_ub, r_lk, r_rt, r_imm, r_tgt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
